// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the system CPU bus (sync/stb/we/wtbt/ack protocol):
// bus widths, byte-lane select encodings and the initiator state enum.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int unsigned BUS_AW = 16;
    localparam int unsigned BUS_DW = 16;

    localparam logic [1:0] WTBT_LO   = 2'b01;
    localparam logic [1:0] WTBT_HI   = 2'b10;
    localparam logic [1:0] WTBT_WORD = 2'b11;

    // One bus cycle walks IDLE -> ARB -> ADDR -> STB -> END -> IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADDR = 3'd2,
        STB  = 3'd3,
        END  = 3'd4
    } state_t;

endpackage

// File: rtl/bus_dma_master.sv
// -----------------------------------------------------------------------------
// bus_dma_master
// Bus initiator for non-CPU agents (loader, debug port, test harness). Takes
// one request at a time, arbitrates for the bus with bus_req/bus_gnt, runs a
// single sync/stb/ack cycle and reports read data or a timeout error.
//
// Ports
//   clk_sys, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake (accepted only in IDLE)
//   req_addr/we/wtbt/wdata  : request fields, latched on acceptance
//   rsp_valid               : one-cycle completion pulse
//   rsp_rdata, rsp_err      : read data (held) / timeout flag
//   bus_req, bus_gnt        : bus ownership request / grant
//   bus_addr/dout/we/wtbt   : registered address-phase outputs
//   bus_sync, bus_stb       : cycle framing and data strobe
//   bus_din, bus_ack        : responder read data and acknowledge
// -----------------------------------------------------------------------------
module bus_dma_master
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BUS_AW-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_wtbt,
    input  logic [BUS_DW-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [BUS_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [BUS_DW-1:0] bus_dout,
    input  logic [BUS_DW-1:0] bus_din,
    output logic              bus_sync,
    output logic              bus_we,
    output logic [1:0]        bus_wtbt,
    output logic              bus_stb,
    input  logic              bus_ack
);

    state_t            state, state_n;
    logic [BUS_AW-1:0] lat_addr, lat_addr_n;
    logic              lat_we, lat_we_n;
    logic [1:0]        lat_wtbt, lat_wtbt_n;
    logic [BUS_DW-1:0] lat_wdata, lat_wdata_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              err, err_n;

    logic              req_ready_n, rsp_valid_n, rsp_err_n, bus_req_n;
    logic              bus_sync_n, bus_stb_n, bus_we_n;
    logic [BUS_DW-1:0] rsp_rdata_n, bus_dout_n;
    logic [BUS_AW-1:0] bus_addr_n;
    logic [1:0]        bus_wtbt_n;
    logic              in_bus;

    // Next state plus next value of every output; all outputs are then
    // registered so nothing on the bus side reaches an output combinationally.
    always_comb begin
        state_n     = state;
        lat_addr_n  = lat_addr;
        lat_we_n    = lat_we;
        lat_wtbt_n  = lat_wtbt;
        lat_wdata_n = lat_wdata;
        cnt_n       = cnt;
        err_n       = err;
        rsp_rdata_n = rsp_rdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_addr_n  = req_addr;
                    lat_we_n    = req_we;
                    lat_wtbt_n  = req_we ? req_wtbt : 2'b00;
                    lat_wdata_n = req_wdata;
                    state_n     = ARB;
                end
            end
            ARB: begin
                if (bus_gnt) begin
                    state_n = ADDR;
                end
            end
            ADDR: begin
                cnt_n   = '0;
                state_n = STB;
            end
            STB: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    err_n = 1'b0;
                    if (!lat_we) begin
                        rsp_rdata_n = bus_din;
                    end
                    state_n = END;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = END;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            END: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        in_bus      = (state_n == ADDR) || (state_n == STB) || (state_n == END);
        req_ready_n = (state_n == IDLE);
        bus_req_n   = (state_n != IDLE);
        bus_sync_n  = in_bus;
        bus_stb_n   = (state_n == STB);
        bus_addr_n  = in_bus ? lat_addr_n  : '0;
        bus_we_n    = in_bus ? lat_we_n    : 1'b0;
        bus_wtbt_n  = in_bus ? lat_wtbt_n  : 2'b00;
        bus_dout_n  = in_bus ? lat_wdata_n : '0;
        rsp_valid_n = (state_n == END);
        rsp_err_n   = (state_n == END) && err_n;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wtbt  <= 2'b00;
            lat_wdata <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_dout  <= '0;
            bus_sync  <= 1'b0;
            bus_we    <= 1'b0;
            bus_wtbt  <= 2'b00;
            bus_stb   <= 1'b0;
        end else begin
            state     <= state_n;
            lat_addr  <= lat_addr_n;
            lat_we    <= lat_we_n;
            lat_wtbt  <= lat_wtbt_n;
            lat_wdata <= lat_wdata_n;
            cnt       <= cnt_n;
            err       <= err_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            bus_req   <= bus_req_n;
            bus_addr  <= bus_addr_n;
            bus_dout  <= bus_dout_n;
            bus_sync  <= bus_sync_n;
            bus_we    <= bus_we_n;
            bus_wtbt  <= bus_wtbt_n;
            bus_stb   <= bus_stb_n;
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// -----------------------------------------------------------------------------
// tb_bus_dma_master
// Directed bench for bus_dma_master. A transaction-level model tracks when
// each request is accepted, granted and completed (as cycle numbers) and
// derives the expected output levels from those intervals; a compare process
// checks the DUT against it every cycle. Literal checks pin latency, strobe
// widths and data values for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_bus_dma_master;
    import bus_pkg::*;

    localparam int TO = 64;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_wtbt = 2'b00;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din = '0;
    logic        bus_sync;
    logic        bus_we;
    logic [1:0]  bus_wtbt;
    logic        bus_stb;
    logic        bus_ack = 1'b0;

    always #5 clk_sys = ~clk_sys;

    bus_dma_master #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_we   (req_we),
        .req_wtbt (req_wtbt),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .bus_sync (bus_sync),
        .bus_we   (bus_we),
        .bus_wtbt (bus_wtbt),
        .bus_stb  (bus_stb),
        .bus_ack  (bus_ack)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_acc/m_addr/m_end are cycle numbers of acceptance, address phase and
    // completion (-1 = not yet known). Expected outputs follow from them.
    logic        m_busy = 1'b0;
    int          m_acc = -1, m_addr = -1, m_end = -1;
    logic [15:0] m_a = '0, m_d = '0, m_rdata = '0;
    logic        m_we = 1'b0, m_err = 1'b0;
    logic [1:0]  m_wt = 2'b00;
    logic        e_ready = 1'b1, e_req = 1'b0, e_sync = 1'b0, e_stb = 1'b0, e_valid = 1'b0;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_acc = -1; m_addr = -1; m_end = -1;
            m_err = 1'b0; m_rdata = '0;
            e_ready = 1'b1; e_req = 1'b0; e_sync = 1'b0; e_stb = 1'b0; e_valid = 1'b0;
        end else begin
            if (m_busy && cyc == m_end) begin
                m_busy = 1'b0; m_acc = -1; m_addr = -1; m_end = -1;
            end else if (!m_busy && e_ready && req_valid) begin
                m_busy = 1'b1; m_acc = cyc;
                m_a = req_addr; m_we = req_we; m_d = req_wdata;
                m_wt = req_we ? req_wtbt : 2'b00;
            end else if (m_busy && m_addr < 0 && bus_gnt) begin
                m_addr = cyc + 1;
            end else if (m_busy && m_addr >= 0 && cyc > m_addr && m_end < 0) begin
                if (bus_ack) begin
                    m_err = 1'b0;
                    if (!m_we) m_rdata = bus_din;
                    m_end = cyc + 1;
                end else if (cyc - m_addr == TO) begin
                    m_err = 1'b1;
                    m_end = cyc + 1;
                end
            end
            cyc++;
            e_ready = !m_busy;
            e_req   = m_busy;
            e_sync  = m_busy && m_addr >= 0 && cyc >= m_addr;
            e_stb   = e_sync && cyc > m_addr && cyc != m_end;
            e_valid = m_busy && cyc == m_end;
        end
    end

    always @(negedge clk_sys) begin
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("bus_req",   32'(bus_req),   32'(e_req));
        chk("bus_sync",  32'(bus_sync),  32'(e_sync));
        chk("bus_stb",   32'(bus_stb),   32'(e_stb));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        if (e_valid) chk("rsp_err", 32'(rsp_err), 32'(m_err));
        if (e_sync) begin
            chk("bus_addr", 32'(bus_addr), 32'(m_a));
            chk("bus_we",   32'(bus_we),   32'(m_we));
            chk("bus_wtbt", 32'(bus_wtbt), 32'(m_wt));
            chk("bus_dout", 32'(bus_dout), 32'(m_d));
        end
    end

    // ---------------- responder ----------------
    // ack_at = n asserts ack in the n-th cycle counted from the stb rise
    // (it may land past STB on purpose); 0 = never acknowledge.
    int          ack_at = 1;
    int          rn = 0;
    logic        prev_stb = 1'b0;
    logic [15:0] rd_val = '0;

    always @(posedge clk_sys) begin
        #1;
        if (bus_stb && !prev_stb) rn = 1;
        else if (rn > 0 && rn < 200) rn++;
        else rn = 0;
        prev_stb = bus_stb;
        bus_ack  = (rn > 0 && rn == ack_at);
        bus_din  = bus_ack ? rd_val : 16'h0000;
    end

    // ---------------- output monitors ----------------
    int          stb_cnt = 0, sync_cnt = 0, rsp_cnt = 0;
    logic [15:0] last_dout = '0;
    logic        we_all = 1'b1;

    always @(negedge clk_sys) begin
        if (bus_stb) stb_cnt++;
        if (bus_sync) begin
            sync_cnt++;
            last_dout = bus_dout;
            we_all = we_all & bus_we;
        end
        if (rsp_valid) rsp_cnt++;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_mon();
        stb_cnt = 0; sync_cnt = 0; rsp_cnt = 0; we_all = 1'b1;
    endtask

    // Presents the request and waits (bounded) for acceptance; req_valid stays
    // high on return so callers can chain back-to-back requests.
    task automatic issue(input logic [15:0] a, input logic we, input logic [1:0] wt,
                         input logic [15:0] d, output int t_acc);
        req_valid = 1'b1; req_addr = a; req_we = we; req_wtbt = wt; req_wdata = d;
        t_acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (req_ready) begin
                t_acc = cyc;
                @(posedge clk_sys);
                #1;
                break;
            end
        end
        if (t_acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output int t_rsp, output logic [15:0] d, output logic e);
        t_rsp = -1; d = '0; e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (rsp_valid) begin
                t_rsp = cyc; d = rsp_rdata; e = rsp_err;
                break;
            end
        end
        if (t_rsp < 0) chk("rsp_timeout", 32'd0, 32'd1);
        tick();
    endtask

    int          ta, tr;
    int          tb3[3];
    logic [15:0] rd;
    logic        er;
    int          rsp_before;
    logic [1:0]  lanes[3];

    initial begin
        lanes[0] = WTBT_LO; lanes[1] = WTBT_HI; lanes[2] = WTBT_WORD;

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_req",   32'(bus_req),   32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        reset = 1'b0;
        tick();

        // 1: read, gnt already high, ack in first STB cycle
        bus_gnt = 1'b1; ack_at = 1; rd_val = 16'o001330;
        clear_mon();
        issue(16'o177664, 1'b0, 2'b00, 16'h0000, ta);
        req_valid = 1'b0;
        wait_rsp(tr, rd, er);
        tick();
        chk("t1_latency", 32'(tr - ta), 32'd4);
        chk("t1_rdata",   32'(rd), 32'o001330);
        chk("t1_err",     32'(er), 32'd0);
        chk("t1_sync_w",  32'(sync_cnt), 32'd3);
        chk("t1_stb_w",   32'(stb_cnt), 32'd1);

        // 2: word write, gnt delayed 10 cycles
        bus_gnt = 1'b0;
        clear_mon();
        issue(16'o177662, 1'b1, WTBT_WORD, 16'o047400, ta);
        req_valid = 1'b0;
        repeat (10) tick();
        chk("t2_req_wait",  32'(bus_req), 32'd1);
        chk("t2_sync_wait", 32'(sync_cnt), 32'd0);
        bus_gnt = 1'b1;
        wait_rsp(tr, rd, er);
        tick();
        chk("t2_err",    32'(er), 32'd0);
        chk("t2_dout",   32'(last_dout), 32'o047400);
        chk("t2_we",     32'(we_all), 32'd1);
        chk("t2_rsp_n",  32'(rsp_cnt), 32'd1);
        chk("t2_rdata",  32'(rd), 32'o001330);

        // 3: unmapped read, no ack -> timeout
        ack_at = 0;
        clear_mon();
        issue(16'o170000, 1'b0, 2'b00, 16'h0000, ta);
        req_valid = 1'b0;
        wait_rsp(tr, rd, er);
        tick();
        chk("t3_err",   32'(er), 32'd1);
        chk("t3_rdata", 32'(rd), 32'o001330);
        chk("t3_stb_w", 32'(stb_cnt), 32'd64);

        // 4a: ack in the last allowed STB cycle wins
        ack_at = 64; rd_val = 16'o123456;
        clear_mon();
        issue(16'o170002, 1'b0, 2'b00, 16'h0000, ta);
        req_valid = 1'b0;
        wait_rsp(tr, rd, er);
        tick();
        chk("t4a_err",   32'(er), 32'd0);
        chk("t4a_rdata", 32'(rd), 32'o123456);
        chk("t4a_stb_w", 32'(stb_cnt), 32'd64);

        // 4b: ack one cycle too late lands in END and is ignored
        ack_at = 65; rd_val = 16'o077777;
        clear_mon();
        issue(16'o170004, 1'b0, 2'b00, 16'h0000, ta);
        req_valid = 1'b0;
        wait_rsp(tr, rd, er);
        tick();
        chk("t4b_err",   32'(er), 32'd1);
        chk("t4b_rdata", 32'(rd), 32'o123456);
        chk("t4b_stb_w", 32'(stb_cnt), 32'd64);

        // 5: async reset in the middle of STB
        ack_at = 0;
        issue(16'o170006, 1'b0, 2'b00, 16'h0000, ta);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus_stb; i++) tick();
        chk("t5_in_stb", 32'(bus_stb), 32'd1);
        repeat (3) tick();
        rsp_before = rsp_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_stb_async",   32'(bus_stb),   32'd0);
        chk("t5_sync_async",  32'(bus_sync),  32'd0);
        chk("t5_req_async",   32'(bus_req),   32'd0);
        chk("t5_ready_async", 32'(req_ready), 32'd1);
        repeat (2) tick();
        #2;
        reset = 1'b0;
        repeat (3) tick();
        chk("t5_no_rsp", 32'(rsp_cnt), 32'(rsp_before));
        ack_at = 1; rd_val = 16'h5a5a;
        issue(16'o177664, 1'b0, 2'b00, 16'h0000, ta);
        req_valid = 1'b0;
        wait_rsp(tr, rd, er);
        chk("t5_after_rdata", 32'(rd), 32'h5a5a);
        chk("t5_after_err",   32'(er), 32'd0);
        tick();

        // 6: back-to-back byte/word writes with req_valid held
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            issue(16'o160000 + 16'(i), 1'b1, lanes[i], 16'h1100 * 16'(i + 1), tb3[i]);
        end
        req_valid = 1'b0;
        wait_rsp(tr, rd, er);
        tick();
        chk("t6_gap01", 32'(tb3[1] - tb3[0]), 32'd5);
        chk("t6_gap12", 32'(tb3[2] - tb3[1]), 32'd5);
        chk("t6_rsp_n", 32'(rsp_cnt), 32'd3);
        chk("t6_rdata", 32'(rd), 32'h5a5a);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
